// File: rtl/lc3b_types.sv
// Shared LC-3b types for the single-line buffer: line/tag/offset widths, FSM states, byte-merge helper.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_tag;
    typedef logic [2:0]   lc3b_line_offset;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lb_state_t;

    function automatic lc3b_line merge_word(input lc3b_line line, input lc3b_line_offset off,
                                            input logic [1:0] be, input lc3b_word wdata);
        lc3b_line r;
        int       base;
        r    = line;
        base = 16 * int'(off);
        if (be[0]) r[base +: 8]     = wdata[7:0];
        if (be[1]) r[base + 8 +: 8] = wdata[15:8];
        return r;
    endfunction

endpackage

// File: rtl/line_store.sv
// Valid/tag/data storage for one 128-bit line with byte-merge on CPU writes; single-cycle update.
// Lookup and word select are combinational; no backpressure (the FSM sequences all updates).
module line_store
    import lc3b_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  lc3b_line        load_data,
    input  lc3b_line_tag    load_tag,
    input  logic            wr_en,
    input  lc3b_line_offset offset,
    input  logic [1:0]      wr_be,
    input  lc3b_word        wr_data,
    input  lc3b_line_tag    lookup_tag,
    output logic            hit,
    output lc3b_word        rd_word,
    output lc3b_line        line
);

    logic         valid;
    lc3b_line_tag tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            line  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            line  <= load_data;
        end else if (wr_en) begin
            line  <= merge_word(line, offset, wr_be, wr_data);
        end
    end

    assign hit     = valid && (tag == lookup_tag);
    assign rd_word = line[16 * int'(offset) +: 16];

endmodule

// File: rtl/line_buffer.sv
// Single-line write-through buffer between the LC-3b CPU port and a 128-bit physical memory.
// Read hit: mem_resp 1 cycle after request; misses/writes wait on pmem_resp (requests held, no timeout).
// Optional LINE_BUFFER_PERF_EN adds saturating hit_count / miss_count outputs.
module line_buffer
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef LINE_BUFFER_PERF_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    lb_state_t       state, state_nxt;
    logic            hit, wr_en, rd_latch, load;
    lc3b_word        rd_word;
    lc3b_line        line;
    lc3b_line_tag    req_tag;
    lc3b_line_offset req_off;

    assign req_tag = mem_address[15:4];
    assign req_off = mem_address[3:1];
    assign load    = (state == ST_FETCH) && pmem_resp;

    line_store u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (pmem_rdata),
        .load_tag   (req_tag),
        .wr_en      (wr_en),
        .offset     (req_off),
        .wr_be      (mem_byte_enable),
        .wr_data    (mem_wdata),
        .lookup_tag (req_tag),
        .hit        (hit),
        .rd_word    (rd_word),
        .line       (line)
    );

    // Write is checked first so a simultaneous read+write behaves as a write.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_latch  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_write) begin
                    if (hit) begin
                        wr_en     = 1'b1;
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end else if (mem_read) begin
                    if (hit) begin
                        rd_latch  = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: if (pmem_resp) state_nxt = ST_IDLE;
            ST_WRITE: if (pmem_resp) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (rd_latch) mem_rdata <= rd_word;
        end
    end

    // Outputs decode from state, so reset clears them without waiting for a clock.
    assign mem_resp     = (state == ST_RESP);
    assign pmem_read    = (state == ST_FETCH);
    assign pmem_write   = (state == ST_WRITE);
    assign pmem_address = (pmem_read || pmem_write) ? {req_tag, 4'b0000} : 16'h0000;
    assign pmem_wdata   = pmem_write ? line : '0;

`ifdef LINE_BUFFER_PERF_EN
    logic refilled;
    logic idle_req;

    assign idle_req = (state == ST_IDLE) && (mem_read || mem_write);

    // refilled marks the post-FETCH re-evaluation so it is not counted as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refilled   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (load)
                refilled <= 1'b1;
            else if (idle_req)
                refilled <= 1'b0;
            if (idle_req && hit && !refilled && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if (idle_req && !hit && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Directed scoreboard bench for line_buffer with a 3-cycle-latency physical memory model.
module tb_line_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address, mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
`ifdef LINE_BUFFER_PERF_EN
    logic [15:0]  hit_count, miss_count;
`endif

    line_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef LINE_BUFFER_PERF_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;

    logic [15:0]  exp_q[$];
    logic [15:0]  ref_word[logic [15:0]];
    logic [127:0] pm_mem[logic [15:0]];

    int           fetch_cnt = 0;
    int           write_cnt = 0;
    int           both_cnt  = 0;
    logic [15:0]  last_fetch_addr = '0;
    logic [15:0]  last_write_addr = '0;
    logic [127:0] last_write_line = '0;

    function automatic logic [15:0] pat(input logic [15:0] waddr);
        if (waddr == 16'h1006) return 16'hBEEF;
        return waddr ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] ref_lookup(input logic [15:0] waddr);
        if (ref_word.exists(waddr)) return ref_word[waddr];
        return pat(waddr);
    endfunction

    function automatic logic [127:0] pm_line(input logic [15:0] base);
        logic [127:0] l;
        if (pm_mem.exists(base)) return pm_mem[base];
        for (int k = 0; k < 8; k++) l[16*k +: 16] = pat(base + 16'(2*k));
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Physical memory: responds on the third cycle a request is seen.
    initial begin : pmem_model
        int pm_cnt;
        pm_cnt     = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (pmem_read && pmem_write) both_cnt++;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pm_cnt    = 0;
            end else if (pmem_read || pmem_write) begin
                pm_cnt++;
                if (pm_cnt == 3) begin
                    if (pmem_read) begin
                        pmem_rdata      = pm_line(pmem_address);
                        last_fetch_addr = pmem_address;
                        fetch_cnt++;
                    end else begin
                        pm_mem[pmem_address] = pmem_wdata;
                        last_write_addr      = pmem_address;
                        last_write_line      = pmem_wdata;
                        write_cnt++;
                    end
                    pmem_resp = 1'b1;
                end
            end else begin
                pm_cnt = 0;
            end
        end
    end

    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [1:0] be, input logic [15:0] wd, input int exp_lat);
        logic [15:0] wa, old_w, new_w;
        int          cyc;
        logic        seen;
        wa = {addr[15:1], 1'b0};
        if (wr) begin
            old_w = ref_lookup(wa);
            new_w = old_w;
            if (be[0]) new_w[7:0]  = wd[7:0];
            if (be[1]) new_w[15:8] = wd[15:8];
            ref_word[wa] = new_w;
        end else begin
            exp_q.push_back(ref_lookup(wa));
        end
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_byte_enable = be; mem_wdata = wd;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            seen = mem_resp;
        end
        check({tag, "_resp_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        if (!wr && exp_q.size() > 0) check({tag, "_rdata"}, 32'(mem_rdata), 32'(exp_q.pop_front()));
        if (wr) begin
            check({tag, "_wr_addr"}, 32'(last_write_addr), 32'({addr[15:4], 4'h0}));
            check({tag, "_wr_word"}, 32'(last_write_line[16*int'(addr[3:1]) +: 16]), 32'(new_w));
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        check({tag, "_single_pulse"}, 32'(mem_resp), 32'd0);
    endtask

    initial begin : stim
        int f0, w0;
        logic seen;
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        mem_address = '0; mem_wdata = '0;
        #12;
        check("rst_mem_resp", 32'(mem_resp), 32'd0);
        check("rst_mem_rdata", 32'(mem_rdata), 32'd0);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_pmem_address", 32'(pmem_address), 32'd0);
        check("rst_pmem_wdata_zero", 32'(pmem_wdata == '0), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Read miss then refill re-evaluated as hit.
        do_req("rd_miss_1006", 1'b1, 1'b0, 16'h1006, 2'b00, 16'h0, 5);
        check("fetch_cnt_1", 32'(fetch_cnt), 32'd1);
        check("fetch_addr_1000", 32'(last_fetch_addr), 32'h1000);
`ifdef LINE_BUFFER_PERF_EN
        check("miss_count_1", 32'(miss_count), 32'd1);
        check("hit_count_0", 32'(hit_count), 32'd0);
`endif

        f0 = fetch_cnt; w0 = write_cnt;
        do_req("rd_hit_100e", 1'b1, 1'b0, 16'h100E, 2'b00, 16'h0, 1);
        check("hit_no_pmem", 32'(fetch_cnt - f0 + write_cnt - w0), 32'd0);
`ifdef LINE_BUFFER_PERF_EN
        check("hit_count_1", 32'(hit_count), 32'd1);
`endif

        do_req("wr_hit_1006_hi", 1'b0, 1'b1, 16'h1006, 2'b10, 16'h1234, 4);
        check("wr_cnt_1", 32'(write_cnt), 32'd1);
        do_req("rd_after_wr_1006", 1'b1, 1'b0, 16'h1007, 2'b00, 16'h0, 1);

        // Read and write together must act as a write.
        w0 = write_cnt;
        do_req("rdwr_both_100e", 1'b1, 1'b1, 16'h100E, 2'b11, 16'h7777, 4);
        check("both_is_write", 32'(write_cnt - w0), 32'd1);
        do_req("rd_after_both", 1'b1, 1'b0, 16'h100E, 2'b00, 16'h0, 1);

        f0 = fetch_cnt; w0 = write_cnt;
        do_req("wr_miss_2000", 1'b0, 1'b1, 16'h2000, 2'b11, 16'hA5A5, 8);
        check("wr_miss_fetch", 32'(fetch_cnt - f0), 32'd1);
        check("wr_miss_fetch_addr", 32'(last_fetch_addr), 32'h2000);
        check("wr_miss_write", 32'(write_cnt - w0), 32'd1);

        w0 = write_cnt;
        do_req("wr_be00_2002", 1'b0, 1'b1, 16'h2002, 2'b00, 16'hFFFF, 4);
        check("be00_still_writes", 32'(write_cnt - w0), 32'd1);
        check("be00_word0_kept", 32'(last_write_line[15:0]), 32'hA5A5);

        // Reset in the middle of a fetch.
        mem_read = 1'b1; mem_address = 16'h3008;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = pmem_read;
        end
        check("midfetch_started", 32'(seen), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_drops_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_drops_pmem_addr", 32'(pmem_address), 32'd0);
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        f0 = fetch_cnt;
        do_req("refetch_3008", 1'b1, 1'b0, 16'h3008, 2'b00, 16'h0, 5);
        check("refetch_cnt", 32'(fetch_cnt - f0), 32'd1);
        check("refetch_addr", 32'(last_fetch_addr), 32'h3000);
`ifdef LINE_BUFFER_PERF_EN
        check("miss_after_rst", 32'(miss_count), 32'd1);
        check("hit_after_rst", 32'(hit_count), 32'd0);
`endif
        check("never_rd_and_wr", 32'(both_cnt), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
